// File: rtl/irq_pkg.sv
// Shared types for the interrupt synchronizer/arbiter.
// Holds the FSM encoding and the default source count.
package irq_pkg;

  localparam int NUM_SRC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_sync_arbiter_rr_pick.sv
// Round-robin search: first set bit of elig strictly after ptr,
// wrapping from NUM_SRC-1 back to 0.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] elig,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      k = ID_W'((int'(ptr) + i) % NUM_SRC);
      if (!found && elig[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/sync_low.sv
// Two-flop synchronizer for one asynchronous level.
// Both flops clear on reset.
module sync_low (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/irq_sync_arbiter.sv
// Synchronizes async request lines, latches rising edges as
// pending and grants one eligible source at a time round-robin.
module irq_sync_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_SRC-1:0] async_req,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending
);

  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] sync_d_q, sync_d_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] rise, clr, elig;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               valid_q, valid_d;
  logic               found;
  logic [ID_W-1:0]    pick;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    sync_low u_sync (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (async_req[g]),
      .sync_out (sync[g])
    );
  end

  assign elig = pending_q & mask;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    sync_d_d = sync;
    rise     = sync & ~sync_d_q;
    clr      = '0;
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = pick;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (irq_ack) begin
          clr[id_q] = 1'b1;
          ptr_d     = id_q;
          valid_d   = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // a new edge on the acked source wins over the clear
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_d_q  <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      ptr_q     <= ID_W'(NUM_SRC - 1);
      id_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      sync_d_q  <= sync_d_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pending   = pending_q;

endmodule

// File: doc/irq_sync_arbiter.md
Name: irq_sync_arbiter

Overview:
Multi-source event controller for asynchronous request lines. Each line passes through its own two-flop synchronizer (sync_low). Rising edges are detected and latched as pending. One enabled pending source at a time is granted round-robin to a single consumer, such as the AHB-Lite slave status logic. The block owns sequencing of the synchronizers and arbitration between sources.

Parameters:
NUM_SRC, 4, number of asynchronous request sources (2..16).
ID_W, $clog2(NUM_SRC), width of granted source index.

Ports:
clk  input  1  system clock, all logic on posedge
n_rst  input  1  asynchronous active-low reset
async_req  input  NUM_SRC  raw asynchronous event lines, rising edge = event
mask  input  NUM_SRC  synchronous enable per source, 1 = eligible for grant
irq_ack  input  1  consumer acknowledges current grant
irq_valid  output  1  a grant is being presented
irq_id  output  ID_W  index of granted source, valid while irq_valid = 1
pending  output  NUM_SRC  latched pending events, regardless of mask

Behaviour:
- Reset (n_rst = 0, async, immediate): all synchronizer flops 0; edge-history register 0; pending = 0; irq_valid = 0; irq_id = 0; rr pointer = NUM_SRC-1, so the first search starts at source 0; state = IDLE.
- Sync stage: one sync_low per source produces sync[i]. The edge register holds sync_d[i]. rise[i] = sync[i] & ~sync_d[i].
- Pending set: pending[i] <= 1 on the cycle rise[i] = 1. Events on an already-pending source merge into a single pending bit; there is no counting.
- Latency: async_req[i] rises before clock edge E0.
  - sync[i] = 1 after E1.
  - pending[i] = 1 after E2.
  - irq_valid = 1 after E3, if idle and eligible.
- Eligible vector: elig = pending & mask.
- FSM states: IDLE, GRANT, RELEASE.
  - IDLE: if elig != 0, pick the first set bit searching upward from (ptr+1) mod NUM_SRC, wrapping. Register irq_id, set irq_valid, go to GRANT. Otherwise stay.
  - GRANT: irq_valid = 1; irq_id held stable. On irq_ack = 1: clear pending[irq_id], ptr <= irq_id, irq_valid <= 0, go to RELEASE.
  - RELEASE: one bubble cycle with irq_valid = 0. Always go to IDLE.
- Ack rules:
  - irq_ack outside GRANT is ignored.
  - Ack is sampled in GRANT; irq_valid falls on the next edge.
- Simultaneous set/clear on the same bit (rise[irq_id] on the ack cycle): set wins. Pending stays 1 and the source re-arbitrates later.
- Mask change during GRANT does not withdraw the grant; irq_id stays until ack. Masked sources keep their pending bits and become eligible when unmasked.
- Fairness: after source k is granted, source k has lowest priority in the next search. Pointer wrap-around: a search from NUM_SRC-1 continues at 0.
- Back-to-back grants: minimum spacing is 2 cycles between irq_valid pulses (GRANT → RELEASE → IDLE → GRANT).
- Reset mid-grant: irq_valid drops asynchronously; all pending events are lost.
- irq_id is only meaningful when irq_valid = 1; it holds its last value otherwise.

Decomposition:
- Shared package irq_pkg:
  - state enum (IDLE, GRANT, RELEASE) as 2-bit logic.
  - localparam default NUM_SRC.
- Existing sync_low: instantiated NUM_SRC times via generate.
- One new sub-module, rr_pick: purely combinational. Takes the eligible vector and pointer; outputs found flag and index. Isolates the wrap-around search.
- All state, pending and edge registers live in irq_sync_arbiter.

Test Plan:
1. Reset then idle: hold async_req = 0, mask = 4'hF for 20 cycles → irq_valid = 0, pending = 4'h0, irq_id = 0 throughout.
2. Single event latency: raise async_req[2] before E0 → pending = 4'b0100 after E2; irq_valid = 1, irq_id = 2 after E3. Ack one cycle → irq_valid = 0 and pending = 0 next cycle.
3. Round-robin: raise all four sources together, ack each grant immediately → grant order 0,1,2,3 with irq_valid pulses 2 cycles apart. Then re-raise 0 and 3 → order 0,3, since ptr = 3 wraps the search to 0 first.
4. Masking: pending = 4'b0011, mask = 4'b0010 → grant id 1 only. Source 0 stays pending. Set mask = 4'hF → id 0 granted after the RELEASE bubble.
5. Set-wins collision: while granting id 1, toggle async_req[1] so rise[1] lands on the ack cycle → pending[1] remains 1 and id 1 is granted again.
6. Async reset mid-grant: assert n_rst = 0 between edges while irq_valid = 1 → irq_valid and pending go 0 immediately. After release, the first grant starts from source 0.
